// File: rtl/general_register_file.sv
// general_register_file
// Bank of four general-purpose registers R1-R4 and four scratch registers
// S1-S4. Every enabled register applies the same FunSel operation
// (dec / inc / load I / clear) at a rising edge. Two combinational read
// ports, OutA and OutB, select any of the eight registers.
//
// Build option: define RF_SCRATCH_EN to implement S1-S4. Without it the
// scratch registers do not exist, ScrSel has no effect and read codes 4-7
// return zero. The port list is identical in both builds.
module general_register_file #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [1:0]       FunSel,
  input  logic [3:0]       RegSel,
  input  logic [3:0]       ScrSel,
  input  logic [2:0]       OutASel,
  input  logic [2:0]       OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB
);

  // FunSel encodings shared by every register in the bank
  localparam logic [1:0] FUN_DEC   = 2'b00;
  localparam logic [1:0] FUN_INC   = 2'b01;
  localparam logic [1:0] FUN_LOAD  = 2'b10;
  localparam logic [1:0] FUN_CLEAR = 2'b11;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Next value of one register from its own current contents. Arithmetic
  // wraps modulo 2^WIDTH, so 0 - 1 gives all-ones and all-ones + 1 gives 0.
  function automatic logic [WIDTH-1:0] next_value(
    input logic [WIDTH-1:0] cur,
    input logic [1:0]       fun,
    input logic [WIDTH-1:0] din
  );
    logic [WIDTH-1:0] res;
    case (fun)
      FUN_DEC:   res = cur - ONE;
      FUN_INC:   res = cur + ONE;
      FUN_LOAD:  res = din;
      FUN_CLEAR: res = ZERO;
      default:   res = cur;
    endcase
    return res;
  endfunction

  // General registers R1-R4 (index 0-3)
  logic [WIDTH-1:0] gen_r [4];

  // Scratch contents as seen by the read muxes (index 0-3 = S1-S4)
  logic [WIDTH-1:0] scr_view_s [4];

  // Flattened read bank: 0-3 = R1-R4, 4-7 = S1-S4
  logic [WIDTH-1:0] bank_s [8];

  // General register update: reset wins, otherwise each enabled register
  // applies FunSel to its own current value and disabled ones hold.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int k = 0; k < 4; k++) begin
        gen_r[k] <= ZERO;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (RegSel[k]) begin
          gen_r[k] <= next_value(gen_r[k], FunSel, I);
        end else begin
          gen_r[k] <= gen_r[k];
        end
      end
    end
  end

`ifdef RF_SCRATCH_EN
  // Scratch registers S1-S4 (index 0-3)
  logic [WIDTH-1:0] scr_r [4];

  // Scratch register update: same rules as the general registers, gated
  // by ScrSel instead of RegSel.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int k = 0; k < 4; k++) begin
        scr_r[k] <= ZERO;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (ScrSel[k]) begin
          scr_r[k] <= next_value(scr_r[k], FunSel, I);
        end else begin
          scr_r[k] <= scr_r[k];
        end
      end
    end
  end

  // Expose the implemented scratch registers to the read muxes
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      scr_view_s[k] = scr_r[k];
    end
  end
`else
  // ScrSel is folded into a constant-zero term so it stays a connected
  // input while having no influence on any output.
  logic scr_sel_ignored_s;
  assign scr_sel_ignored_s = ^ScrSel;

  // No scratch storage in this build: read codes 4-7 always return zero
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      scr_view_s[k] = ZERO & {WIDTH{scr_sel_ignored_s}};
    end
  end
`endif

  // Assemble the eight read sources into one indexable bank
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      bank_s[k]     = gen_r[k];
      bank_s[k + 4] = scr_view_s[k];
    end
  end

  // Combinational read ports: zero latency, pre-edge value until the edge
  always_comb begin
    OutA = bank_s[OutASel];
    OutB = bank_s[OutBSel];
  end

endmodule

// File: tb/tb_general_register_file.sv
// Self-checking bench for general_register_file: a table of
// {inputs, expected outputs} records plus hand-written sequences for reset
// and same-cycle read/write. Expected values are pushed to a scoreboard
// queue when stimulus is driven and popped when outputs are sampled.
module tb_general_register_file;

  localparam int W = 16;

`ifdef RF_SCRATCH_EN
  localparam bit SCR = 1'b1;
`else
  localparam bit SCR = 1'b0;
`endif

  logic         Clock;
  logic         Reset;
  logic [W-1:0] I;
  logic [1:0]   FunSel;
  logic [3:0]   RegSel;
  logic [3:0]   ScrSel;
  logic [2:0]   OutASel;
  logic [2:0]   OutBSel;
  logic [W-1:0] OutA;
  logic [W-1:0] OutB;

  general_register_file #(.WIDTH(W)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .I      (I),
    .FunSel (FunSel),
    .RegSel (RegSel),
    .ScrSel (ScrSel),
    .OutASel(OutASel),
    .OutBSel(OutBSel),
    .OutA   (OutA),
    .OutB   (OutB)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Protocol check: FunSel must be known whenever any register is enabled
  always @(posedge Clock) begin
    if (!Reset && ((RegSel != 4'b0000) || (ScrSel != 4'b0000))) begin
      assert (!$isunknown(FunSel))
        else $error("FAIL funsel_x FunSel=%b with nonzero mask", FunSel);
    end
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]   regsel;
    logic [3:0]   scrsel;
    logic [1:0]   fun;
    logic [W-1:0] din;
    logic [2:0]   asel;
    logic [2:0]   bsel;
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  vec_t vecs [18];
  exp_t sb_q [$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Pop one scoreboard entry and compare both ports against it
  task automatic sample();
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty got=%h expected=entry", OutA);
    end else begin
      e = sb_q.pop_front();
      check({e.name, "_A"}, OutA, e.a);
      check({e.name, "_B"}, OutB, e.b);
    end
  endtask

  // Drive one cycle of stimulus, push its expectation, sample at negedge
  task automatic step(input string name, input logic rst, input logic [3:0] rs, input logic [3:0] ss,
                      input logic [1:0] fs, input logic [W-1:0] din, input logic [2:0] as,
                      input logic [2:0] bs, input logic [W-1:0] ea, input logic [W-1:0] eb);
    exp_t e;
    Reset = rst; RegSel = rs; ScrSel = ss; FunSel = fs; I = din;
    OutASel = as; OutBSel = bs;
    e.name = name; e.a = ea; e.b = eb;
    sb_q.push_back(e);
    @(posedge Clock);
    @(negedge Clock);
    sample();
  endtask

  initial begin
    // Stimulus table applied after the reset test (all registers start at 0)
    vecs[0]  = '{4'b0101, 4'b0000, 2'b10, 16'hBEEF, 3'd2, 3'd1, 16'hBEEF, 16'h0000};
    vecs[1]  = '{4'b0000, 4'b0000, 2'b00, 16'h0000, 3'd0, 3'd3, 16'hBEEF, 16'h0000};
    vecs[2]  = '{4'b0010, 4'b0000, 2'b00, 16'h0000, 3'd1, 3'd0, 16'hFFFF, 16'hBEEF};
    vecs[3]  = '{4'b0010, 4'b0000, 2'b01, 16'h0000, 3'd1, 3'd0, 16'h0000, 16'hBEEF};
    vecs[4]  = '{4'b0000, 4'b0000, 2'b11, 16'h1111, 3'd0, 3'd2, 16'hBEEF, 16'hBEEF};
    vecs[5]  = '{4'b0000, 4'b0000, 2'b11, 16'h2222, 3'd0, 3'd2, 16'hBEEF, 16'hBEEF};
    vecs[6]  = '{4'b0000, 4'b0000, 2'b11, 16'h3333, 3'd0, 3'd2, 16'hBEEF, 16'hBEEF};
    vecs[7]  = '{4'b1000, 4'b0000, 2'b10, 16'h5A00, 3'd3, 3'd1, 16'h5A00, 16'h0000};
    vecs[8]  = '{4'b0000, 4'b1000, 2'b10, 16'h00A5, 3'd7, 3'd3, SCR ? 16'h00A5 : 16'h0000, 16'h5A00};
    vecs[9]  = '{4'b0001, 4'b0000, 2'b10, 16'h0010, 3'd0, 3'd7, 16'h0010, SCR ? 16'h00A5 : 16'h0000};
    vecs[10] = '{4'b1111, 4'b0000, 2'b01, 16'h0000, 3'd2, 3'd1, 16'hBEF0, 16'h0001};
    vecs[11] = '{4'b0000, 4'b1111, 2'b11, 16'h0000, 3'd7, 3'd0, 16'h0000, 16'h0011};
    vecs[12] = '{4'b0000, 4'b0001, 2'b00, 16'h0000, 3'd4, 3'd5, SCR ? 16'hFFFF : 16'h0000, 16'h0000};
    vecs[13] = '{4'b0000, 4'b0001, 2'b01, 16'h0000, 3'd4, 3'd0, 16'h0000, 16'h0011};
    vecs[14] = '{4'b1000, 4'b0000, 2'b01, 16'h0000, 3'd3, 3'd3, 16'h5A02, 16'h5A02};
    vecs[15] = '{4'b0001, 4'b0000, 2'b10, 16'hFFFF, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF};
    vecs[16] = '{4'b0001, 4'b0000, 2'b01, 16'h0000, 3'd0, 3'd0, 16'h0000, 16'h0000};
    vecs[17] = '{4'b0000, 4'b0001, 2'b10, 16'hC3C3, 3'd4, 3'd2, SCR ? 16'hC3C3 : 16'h0000, 16'hBEF0};

    Reset = 1'b1; RegSel = 4'b0000; ScrSel = 4'b0000; FunSel = 2'b11;
    I = 16'h0000; OutASel = 3'd0; OutBSel = 3'd0;
    @(negedge Clock);

    // Power-up reset, then load R1 so the following reset has work to undo
    step("init_reset", 1'b1, 4'b1111, 4'b1111, 2'b11, 16'h0000, 3'd0, 3'd4, 16'h0000, 16'h0000);
    step("load_r1",    1'b0, 4'b0001, 4'b0000, 2'b10, 16'h1234, 3'd0, 3'd0, 16'h1234, 16'h1234);
    // Reset has priority over an increment of every register
    step("reset_prio", 1'b1, 4'b1111, 4'b1111, 2'b01, 16'h0000, 3'd0, 3'd0, 16'h0000, 16'h0000);
    for (int s = 1; s < 8; s++) begin
      step("reset_sweep", 1'b0, 4'b0000, 4'b0000, 2'b11, 16'h0000, 3'(s), 3'(7 - s), 16'h0000, 16'h0000);
    end

    // Table-driven main sequence
    for (int v = 0; v < 18; v++) begin
      step($sformatf("vec%0d", v), 1'b0, vecs[v].regsel, vecs[v].scrsel, vecs[v].fun, vecs[v].din,
           vecs[v].asel, vecs[v].bsel, vecs[v].exp_a, vecs[v].exp_b);
    end

    // Same-cycle read/write: pre-edge value visible until the edge
    step("rmw_load", 1'b0, 4'b0001, 4'b0000, 2'b10, 16'h0010, 3'd0, 3'd0, 16'h0010, 16'h0010);
    Reset = 1'b0; RegSel = 4'b0001; ScrSel = 4'b0000; FunSel = 2'b01; I = 16'h0000;
    OutASel = 3'd0; OutBSel = 3'd0;
    #1;
    check("rmw_before_edge", OutA, 16'h0010);
    @(posedge Clock);
    #1;
    check("rmw_after_edge", OutA, 16'h0011);
    RegSel = 4'b0000;
    @(negedge Clock);

    // Reset mid-sequence discards a pending load on every register
    step("mid_reset", 1'b1, 4'b1111, 4'b1111, 2'b10, 16'hFFFF, 3'd0, 3'd7, 16'h0000, 16'h0000);
    for (int s = 0; s < 4; s++) begin
      step("mid_reset_sweep", 1'b0, 4'b0000, 4'b0000, 2'b00, 16'h0000, 3'(s), 3'(s + 4), 16'h0000, 16'h0000);
    end

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/general_register_file.md
Name: general_register_file

Overview:
- Bank of four general-purpose registers R1–R4 and four scratch registers S1–S4, each WIDTH bits.
- Every register honours the 2-bit FunSel operation set of the datapath registers: decrement, increment, load, clear.
- Sits between the ALU result/memory bus (input I) and the ALU operand muxes (OutA/OutB).
- Driven each cycle by the control unit through select masks and FunSel.

Parameters:
- WIDTH, 16, data width of every register, of I, and of OutA/OutB.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- I  input  WIDTH  load data.
- FunSel  input  2  operation applied to all enabled registers: 00 dec, 01 inc, 10 load I, 11 clear.
- RegSel  input  4  active-high enable mask for the general registers; bit0=R1 … bit3=R4.
- ScrSel  input  4  active-high enable mask for the scratch registers; bit0=S1 … bit3=S4.
- OutASel  input  3  read select for port A; 0–3 = R1–R4, 4–7 = S1–S4.
- OutBSel  input  3  read select for port B; same encoding as OutASel.
- OutA  output  WIDTH  contents of the register selected by OutASel.
- OutB  output  WIDTH  contents of the register selected by OutBSel.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high (Clock, Reset).
- Reset:
  - Reset=1 at a rising edge clears all eight registers to 0.
  - Reset has priority over FunSel and all select masks.
  - OutA/OutB read 0 from the cycle after that edge.
  - Reset asserted mid-sequence discards any pending operation that cycle.
- Write:
  - At each rising edge with Reset=0, every register whose select bit is 1 updates per FunSel.
  - Registers with select bit 0 hold their value.
  - Multiple set bits apply the identical operation to all selected registers in the same cycle; this is legal and intended.
  - Both masks all-zero: no state change.
- Arithmetic:
  - Modulo 2^WIDTH, unsigned.
  - Decrement of 0 gives all-ones (16'hFFFF); increment of all-ones gives 0.
  - No flags are produced.
- Read:
  - Purely combinational muxes; zero-cycle latency from OutASel/OutBSel.
  - A value written at edge N is visible on OutA/OutB after edge N.
  - No same-cycle write-through.
  - OutA and OutB may select the same register.
- Read-modify-write:
  - Each register updates from its own current Q.
  - Simultaneous read of a register being written returns the pre-edge value until the edge.
- Reset values:
  - All registers 0.
  - OutA = OutB = 0 whenever the selected register is 0. There are no other registered outputs.
- Unknowns: X on FunSel with a nonzero mask is a protocol error; the bench checks this with an assertion.

Optional Feature:
- Macro RF_SCRATCH_EN.
- Defined:
  - S1–S4 are implemented as above.
  - ScrSel is active.
  - Read codes 4–7 return S1–S4.
- Undefined:
  - The scratch registers are not instantiated and ScrSel is ignored.
  - Read codes 4–7 return 0.
  - Port list is unchanged.

Test Plan:
- Reset=1 for one edge after loading R1=16'h1234 → OutA (sel 0) and OutB (sel 0) read 16'h0000 next cycle; RegSel=4'b1111 with FunSel=01 in the reset cycle has no effect.
- RegSel=4'b0101, FunSel=10, I=16'hBEEF, one edge → R1=R3=16'hBEEF, R2=R4 unchanged (0); OutASel=2 → 16'hBEEF.
- R2=16'h0000, FunSel=00 one edge → 16'hFFFF; then FunSel=01 one edge → 16'h0000.
- RegSel=0, ScrSel=0, FunSel=11 for 3 edges → all contents unchanged (R1 still 16'hBEEF).
- Load S4=16'h00A5 (ScrSel=4'b1000) while R4=16'h5A00 → OutASel=7 shows 16'h00A5 and OutBSel=3 shows 16'h5A00 with RF_SCRATCH_EN defined; without the macro OutASel=7 shows 16'h0000.
- Same-cycle read/write: OutASel=0, R1=16'h0010, FunSel=01, RegSel=4'b0001 → OutA = 16'h0010 before the edge and 16'h0011 after it.
